// File: rtl/debounced_switch_counter_if.sv
// Switch inputs and count/strobe outputs of the debounced up/down counter.
// The master side drives the raw buttons; the slave side is the counter.
interface debounced_switch_counter_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   i_Switch_Up;
    logic                   i_Switch_Down;
    logic [COUNT_WIDTH-1:0] o_Count;
    logic                   o_Up_Pulse;
    logic                   o_Down_Pulse;

    modport master (
        output i_Switch_Up,
        output i_Switch_Down,
        input  o_Count,
        input  o_Up_Pulse,
        input  o_Down_Pulse
    );

    modport slave (
        input  i_Switch_Up,
        input  i_Switch_Down,
        output o_Count,
        output o_Up_Pulse,
        output o_Down_Pulse
    );
endinterface

// File: rtl/debounced_switch_counter.sv
// Debounces the up/down buttons and counts debounced releases, wrapping in both directions.
// Index 0 of the per-switch arrays is the up button, index 1 the down button.
module debounced_switch_counter #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int COUNT_WIDTH    = 8
) (
    input logic                     i_Clk,
    input logic                     i_Rst_L,
    debounced_switch_counter_if.slave sw_if
);
    localparam int CW = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

    logic [1:0]             raw;
    logic [1:0]             sync1_q;
    logic [1:0]             sync2_q;
    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [1:0]             release_d;
    logic [CW-1:0]          cnt_q [2];
    logic [CW-1:0]          cnt_d [2];
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   up_pulse_q;
    logic                   up_pulse_d;
    logic                   down_pulse_q;
    logic                   down_pulse_d;

    assign raw = {sw_if.i_Switch_Down, sw_if.i_Switch_Up};

    // A release is the flip of a debounced level from 1 to 0; it is decoded on the
    // same edge that flips the level so the count and strobe move together.
    always_comb begin
        state_d   = state_q;
        release_d = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    state_d[i]   = sync2_q[i];
                    release_d[i] = state_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Simultaneous up and down releases cancel in the count but both still strobe.
    always_comb begin
        count_d      = count_q;
        up_pulse_d   = release_d[0];
        down_pulse_d = release_d[1];
        case (release_d)
            2'b01:   count_d = count_q + COUNT_WIDTH'(1);
            2'b10:   count_d = count_q - COUNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            state_q      <= '0;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            count_q      <= '0;
            up_pulse_q   <= 1'b0;
            down_pulse_q <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            count_q      <= count_d;
            up_pulse_q   <= up_pulse_d;
            down_pulse_q <= down_pulse_d;
        end
    end

    assign sw_if.o_Count      = count_q;
    assign sw_if.o_Up_Pulse   = up_pulse_q;
    assign sw_if.o_Down_Pulse = down_pulse_q;
endmodule

// File: tb/tb_debounced_switch_counter.sv
// Self-checking bench for debounced_switch_counter with a short debounce window.
// The reference model flips a debounced level once the synchronised input has sat at the other level for L cycles.
module tb_debounced_switch_counter;
    localparam int L  = 4;
    localparam int CW = 8;

    logic i_Clk;
    logic i_Rst_L;

    debounced_switch_counter_if #(.COUNT_WIDTH(CW)) sw_if ();

    debounced_switch_counter #(
        .DEBOUNCE_LIMIT (L),
        .COUNT_WIDTH    (CW)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .sw_if   (sw_if.slave)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int err_count   = 0;
    int check_count = 0;

    // Raw samples, newest in bit 0; bits L:1 are what the synchroniser has delivered over the last L edges.
    logic [L:0] hist_up;
    logic [L:0] hist_dn;
    bit         m_up_lvl;
    bit         m_dn_lvl;
    int         m_count;
    bit         exp_up;
    bit         exp_dn;
    int         obs_up;
    int         obs_dn;
    int         obs_both;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        hist_up  = '0;
        hist_dn  = '0;
        m_up_lvl = 1'b0;
        m_dn_lvl = 1'b0;
        m_count  = 0;
        exp_up   = 1'b0;
        exp_dn   = 1'b0;
    endfunction

    function automatic void modelStep(input bit up, input bit dn);
        bit flip_up;
        bit flip_dn;
        flip_up = m_up_lvl ? (hist_up[L:1] == '0) : (&hist_up[L:1]);
        flip_dn = m_dn_lvl ? (hist_dn[L:1] == '0) : (&hist_dn[L:1]);
        exp_up  = flip_up && m_up_lvl;
        exp_dn  = flip_dn && m_dn_lvl;
        if (flip_up) m_up_lvl = !m_up_lvl;
        if (flip_dn) m_dn_lvl = !m_dn_lvl;
        if (exp_up && !exp_dn) m_count = (m_count + 1) % 256;
        if (exp_dn && !exp_up) m_count = (m_count + 255) % 256;
        hist_up = {hist_up[L-1:0], up};
        hist_dn = {hist_dn[L-1:0], dn};
    endfunction

    // Called #1 after an edge; drives the buttons for the next edge and checks the result of that edge.
    task automatic applyStimulus(input bit up, input bit dn);
        sw_if.i_Switch_Up   = up;
        sw_if.i_Switch_Down = dn;
        @(posedge i_Clk);
        modelStep(up, dn);
        #1;
        checkOutput("count", 32'(sw_if.o_Count), 32'(m_count));
        checkOutput("up_pulse", 32'(sw_if.o_Up_Pulse), 32'(exp_up));
        checkOutput("down_pulse", 32'(sw_if.o_Down_Pulse), 32'(exp_dn));
        if (sw_if.o_Up_Pulse) obs_up++;
        if (sw_if.o_Down_Pulse) obs_dn++;
        if (sw_if.o_Up_Pulse && sw_if.o_Down_Pulse) obs_both++;
    endtask

    task automatic hold(input bit up, input bit dn, input int n);
        for (int i = 0; i < n; i++) applyStimulus(up, dn);
    endtask

    task automatic releaseUp();
        hold(1'b1, 1'b0, L + 4);
        hold(1'b0, 1'b0, L + 4);
    endtask

    task automatic releaseDown();
        hold(1'b0, 1'b1, L + 4);
        hold(1'b0, 1'b0, L + 4);
    endtask

    // Reset is asserted between edges so its effect is visible before any clock arrives.
    task automatic doReset();
        i_Rst_L = 1'b0;
        #1;
        modelReset();
        checkOutput("reset_count", 32'(sw_if.o_Count), 32'd0);
        checkOutput("reset_up_pulse", 32'(sw_if.o_Up_Pulse), 32'd0);
        checkOutput("reset_down_pulse", 32'(sw_if.o_Down_Pulse), 32'd0);
        @(negedge i_Clk);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        @(posedge i_Clk);
        #1;
    endtask

    initial begin
        bit r_up;
        bit r_dn;
        int t;
        sw_if.i_Switch_Up   = 1'b0;
        sw_if.i_Switch_Down = 1'b0;
        i_Rst_L             = 1'b1;
        obs_up   = 0;
        obs_dn   = 0;
        obs_both = 0;
        modelReset();
        @(posedge i_Clk);
        #1;
        doReset();

        // Clean press and release: exactly one increment, landing on the 6th edge after the fall.
        obs_up = 0;
        hold(1'b1, 1'b0, 20);
        checkOutput("t1_no_count_on_press", 32'(sw_if.o_Count), 32'd0);
        hold(1'b0, 1'b0, L + 1);
        checkOutput("t1_before_edge6", 32'(sw_if.o_Count), 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t1_at_edge6", 32'(sw_if.o_Count), 32'd1);
        checkOutput("t1_pulse_at_edge6", 32'(sw_if.o_Up_Pulse), 32'd1);
        hold(1'b0, 1'b0, 13);
        checkOutput("t1_pulse_total", 32'(obs_up), 32'd1);

        // Bounce with 2-cycle phases never stays stable for L cycles.
        for (int i = 0; i < 2; i++) begin
            hold(1'b1, 1'b0, 2);
            hold(1'b0, 1'b0, 2);
        end
        hold(1'b0, 1'b0, 10);
        checkOutput("t2_bounce_count", 32'(sw_if.o_Count), 32'd1);

        // Wrap in both directions.
        doReset();
        releaseDown();
        checkOutput("t3_down_wrap", 32'(sw_if.o_Count), 32'd255);
        releaseUp();
        checkOutput("t3_up_wrap", 32'(sw_if.o_Count), 32'd0);

        // Simultaneous releases from 0x10 cancel but both strobe.
        for (int i = 0; i < 16; i++) releaseUp();
        checkOutput("t4_start", 32'(sw_if.o_Count), 32'h10);
        obs_both = 0;
        hold(1'b1, 1'b1, L + 4);
        hold(1'b0, 1'b0, L + 4);
        checkOutput("t4_count_held", 32'(sw_if.o_Count), 32'h10);
        checkOutput("t4_both_pulses", 32'(obs_both), 32'd1);

        // Mixed sequence, then reset in the middle of a release debounce.
        doReset();
        for (int i = 0; i < 5; i++) releaseUp();
        for (int i = 0; i < 2; i++) releaseDown();
        checkOutput("t5_count", 32'(sw_if.o_Count), 32'd3);
        hold(1'b1, 1'b0, L + 4);
        hold(1'b0, 1'b0, 3);
        doReset();
        obs_up = 0;
        hold(1'b0, 1'b0, 12);
        checkOutput("t5_no_pulse_after_reset", 32'(obs_up), 32'd0);

        // Button held through reset deassertion counts on its later release.
        hold(1'b1, 1'b0, 3);
        doReset();
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 10);
        checkOutput("held_through_reset", 32'(sw_if.o_Count), 32'd1);

        // Long hold gives no repeat events.
        obs_up = 0;
        hold(1'b1, 1'b0, 100);
        checkOutput("t6_hold_count", 32'(sw_if.o_Count), 32'd1);
        checkOutput("t6_hold_pulses", 32'(obs_up), 32'd0);
        hold(1'b0, 1'b0, 10);

        // Random switching, compared cycle by cycle against the model.
        r_up = 1'b0;
        r_dn = 1'b0;
        for (t = 0; t < 600; t++) begin
            if ($urandom_range(0, 5) == 0) r_up = !r_up;
            if ($urandom_range(0, 5) == 0) r_dn = !r_dn;
            applyStimulus(r_up, r_dn);
        end
        hold(1'b0, 1'b0, 20);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end
endmodule
